// File: rtl/design_mux_pkg.sv
// Shared types and helpers for the sequenced pad mux: FSM state encoding,
// the "no design" id and the per-design bus slice extractor.
package design_mux_pkg;

    typedef enum logic [1:0] {
        PARKED     = 2'd0,
        DRAIN      = 2'd1,
        RESET_HOLD = 2'd2,
        ACTIVE     = 2'd3
    } mux_state_e;

    localparam int MAX_ID_W  = 16;
    localparam int MAX_IO_W  = 64;
    localparam int MAX_BUS_W = 1024;

    // All-ones never names a real slot; narrow it with a cast to the local id width.
    localparam logic [MAX_ID_W-1:0] ID_NONE = '1;

    // Slot idx of a bus packed as idx*width +: width; callers cast down to their width.
    function automatic logic [MAX_IO_W-1:0] bus_slice(input logic [MAX_BUS_W-1:0] bus,
                                                       input int unsigned idx,
                                                       input int unsigned width);
        return MAX_IO_W'(bus >> (idx * width));
    endfunction

endpackage

// File: rtl/design_mux_seq_filter.sv
// Stability filter: a requested id is accepted only after it has been held
// for STABLE_CYCLES consecutive cycles; glitches shorter than that vanish.
module sel_stable_filter
    import design_mux_pkg::*;
#(
    parameter int W             = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] sel_i,
    output logic [W-1:0] accepted_o,
    output logic         accept_o
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [W-1:0] cand_q, cand_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [W-1:0] accepted_q, accepted_d;

    // NOTE: every output of this block is given a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (sel_i != cand_q) begin
            cand_d = sel_i;
            cnt_d  = 8'd1;
        end else if (cnt_q != STABLE) begin
            cnt_d = cnt_q + 8'd1;
        end
        accept_o   = (cnt_d == STABLE) && ((cnt_q != STABLE) || (sel_i != cand_q));
        accepted_d = accept_o ? cand_d : accepted_q;
    end

    assign accepted_o = accepted_d;

    // NOTE: state registers use non-blocking assignments so all of them sample the same pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cand_q     <= '1;
            cnt_q      <= 8'd0;
            accepted_q <= '1;
        end else begin
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            accepted_q <= accepted_d;
        end
    end

endmodule

// File: rtl/design_mux_seq.sv
// Sequenced pad mux: drains pads, holds the incoming design in reset, then connects it.
// sel_id change to first driven pad is STABLE_CYCLES + GUARD_CYCLES + RST_CYCLES + 1 cycles.
module design_mux_seq
    import design_mux_pkg::*;
#(
    parameter int NUM_DESIGNS   = 4,
    parameter int ID_W          = 4,
    parameter int IO_W          = 38,
    parameter int FIRST_IO      = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int GUARD_CYCLES  = 8,
    parameter int RST_CYCLES    = 16
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [ID_W-1:0]             sel_id,
    input  logic [3:0]                  debug,
    input  logic [IO_W-1:0]             io_in,
    output logic [IO_W-1:0]             io_out,
    output logic [IO_W-1:0]             io_oeb,
    output logic [IO_W-1:0]             des_io_in,
    input  logic [NUM_DESIGNS*IO_W-1:0] des_io_out,
    input  logic [NUM_DESIGNS*IO_W-1:0] des_io_oeb,
    output logic [NUM_DESIGNS-1:0]      des_rst,
    output logic [ID_W-1:0]             active_id,
    output logic                        busy
);

    localparam logic [ID_W-1:0] NONE_ID    = ID_W'(ID_NONE);
    localparam logic [7:0]      GUARD_LOAD = 8'(GUARD_CYCLES - 1);
    localparam logic [7:0]      RST_LOAD   = 8'(RST_CYCLES - 1);
    // Ones on the managed pads, zeros on the always-disabled low pads.
    localparam logic [IO_W-1:0] PAD_MASK   = ~IO_W'((64'd1 << FIRST_IO) - 64'd1);

    mux_state_e             state_q, state_d;
    logic [ID_W-1:0]        target_q, target_d;
    logic [7:0]             phase_q, phase_d;
    logic [IO_W-1:0]        io_out_q, io_out_d, io_oeb_q, io_oeb_d, des_io_in_q;
    logic [NUM_DESIGNS-1:0] des_rst_q, des_rst_d;
    logic [ID_W-1:0]        active_id_q, active_id_d;
    logic                   busy_q, busy_d;

    logic [ID_W-1:0] accepted;
    logic            accept;
    logic            trigger;
    logic            drive;
    logic [IO_W-1:0] sel_out, sel_oeb;
    logic            unused_debug;

    assign unused_debug = ^debug[3:1];

    sel_stable_filter #(
        .W            (ID_W),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .sel_i     (sel_id),
        .accepted_o(accepted),
        .accept_o  (accept)
    );

    // A fresh acceptance that differs from the target restarts the sequence from any state.
    assign trigger = accept && (accepted != target_q);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        phase_d  = phase_q;
        if (trigger) begin
            target_d = accepted;
            state_d  = DRAIN;
            phase_d  = GUARD_LOAD;
        end else begin
            case (state_q)
                DRAIN: begin
                    if (phase_q == 8'd0) begin
                        if (32'(target_q) < NUM_DESIGNS) begin
                            state_d = RESET_HOLD;
                            phase_d = RST_LOAD;
                        end else begin
                            state_d = PARKED;
                        end
                    end else begin
                        phase_d = phase_q - 8'd1;
                    end
                end
                RESET_HOLD: begin
                    if (phase_q == 8'd0) state_d = ACTIVE;
                    else                 phase_d = phase_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sel_out = IO_W'(bus_slice(MAX_BUS_W'(des_io_out), 32'(target_q), IO_W));
        sel_oeb = IO_W'(bus_slice(MAX_BUS_W'(des_io_oeb), 32'(target_q), IO_W));
        // Pads switch to safe on the same edge the FSM leaves ACTIVE, not one later.
        drive    = (state_q == ACTIVE) && (state_d == ACTIVE) && !debug[0];
        io_out_d = drive ? (sel_out & PAD_MASK) : '0;
        io_oeb_d = drive ? (sel_oeb | ~PAD_MASK) : '1;
        for (int d = 0; d < NUM_DESIGNS; d++) begin
            des_rst_d[d] = !((state_d == ACTIVE) && (target_d == ID_W'(d)));
        end
        active_id_d = (state_d == ACTIVE) ? target_d : NONE_ID;
        busy_d      = (state_d == DRAIN) || (state_d == RESET_HOLD);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= PARKED;
            target_q    <= NONE_ID;
            phase_q     <= 8'd0;
            io_out_q    <= '0;
            io_oeb_q    <= '1;
            des_io_in_q <= '0;
            des_rst_q   <= '1;
            active_id_q <= NONE_ID;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            phase_q     <= phase_d;
            io_out_q    <= io_out_d;
            io_oeb_q    <= io_oeb_d;
            des_io_in_q <= io_in;
            des_rst_q   <= des_rst_d;
            active_id_q <= active_id_d;
            busy_q      <= busy_d;
        end
    end

    assign io_out    = io_out_q;
    assign io_oeb    = io_oeb_q;
    assign des_io_in = des_io_in_q;
    assign des_rst   = des_rst_q;
    assign active_id = active_id_q;
    assign busy      = busy_q;

endmodule

// File: doc/design_mux_seq.md
Name: design_mux_seq

Overview:
- Parametrised, sequenced successor to the static top-level design mux. It connects one of NUM_DESIGNS user designs to the managed IO pads, chosen by the LA-driven sel_id.
- On every selection change it runs a safe switch-over: drain the pads to input mode, hold the incoming design in reset, then connect it.
- Non-selected designs are held in reset.
- Sits in user_project_wrapper between the pads and the design macros; controlled from LA bits.

Parameters:
- NUM_DESIGNS, 4, number of design slots; valid ids are 0..NUM_DESIGNS-1.
- ID_W, 4, width of sel_id; must satisfy 2**ID_W > NUM_DESIGNS, so an all-ones id is always "none".
- IO_W, 38, pad vector width.
- FIRST_IO, 8, lowest pad index this block drives; pads below it are output-disabled (oeb=1, out=0) at all times.
- STABLE_CYCLES, 4, consecutive cycles sel_id must hold a value before it is accepted (1..255).
- GUARD_CYCLES, 8, DRAIN duration in cycles (1..255).
- RST_CYCLES, 16, RESET_HOLD duration in cycles (1..255).

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  asynchronous, active-high reset
- sel_id  in  ID_W  requested design id, from LA
- debug  in  4  bit0 = force safe (all pads input); bits 3:1 reserved, ignored
- io_in  in  IO_W  pad inputs
- io_out  out  IO_W  pad outputs, registered
- io_oeb  out  IO_W  pad output-enable-bar, registered
- des_io_in  out  IO_W  registered copy of io_in, broadcast to all designs
- des_io_out  in  NUM_DESIGNS*IO_W  design d occupies bits [d*IO_W +: IO_W]
- des_io_oeb  in  NUM_DESIGNS*IO_W  same packing as des_io_out
- des_rst  out  NUM_DESIGNS  per-design active-high reset
- active_id  out  ID_W  id currently connected; all-ones = none
- busy  out  1  high in DRAIN or RESET_HOLD

Behaviour:
- Reset (async assert on wb_rst_i, synchronous release):
  - state=PARKED; active_id and target both all-ones.
  - des_rst all 1; io_oeb all 1; io_out all 0; des_io_in 0; busy 0.
  - Filter cleared: candidate all-ones, count 0.
- Stability filter, registered:
  - If sel_id != candidate: candidate<=sel_id, count<=1.
  - Else count saturates at STABLE_CYCLES.
  - On the cycle count reaches STABLE_CYCLES, accepted<=candidate.
- Switch trigger: accepted != target. Then target<=accepted and state<=DRAIN, from any state, including mid-DRAIN or mid-RESET_HOLD. On a restart the phase counter reloads.
- States:
  - PARKED: all des_rst=1, managed pads oeb=1, out=0, active_id=all-ones.
  - DRAIN: same pad and reset outputs as PARKED, for GUARD_CYCLES cycles. Then:
    - if target < NUM_DESIGNS, go to RESET_HOLD;
    - otherwise go to PARKED.
  - RESET_HOLD: pads as PARKED; des_rst[target]=1, others 1; lasts RST_CYCLES cycles, then ACTIVE.
  - ACTIVE:
    - des_rst[target]=0, others 1; active_id=target.
    - For pads i>=FIRST_IO: io_out[i]<=des_io_out[target*IO_W+i], io_oeb[i]<=des_io_oeb[target*IO_W+i]. This is a one-cycle registered path.
- busy: high in DRAIN and RESET_HOLD, low otherwise. active_id updates on the first ACTIVE cycle, and becomes all-ones on entry to DRAIN.
- des_io_in <= io_in every cycle, regardless of state (one-cycle latency).
- debug[0]=1:
  - Next-cycle io_oeb all 1, io_out all 0.
  - The FSM and des_rst are unaffected.
  - Release resumes normal muxing on the next cycle.
- Minimum switch latency from an sel_id change to the first driven pad: STABLE_CYCLES + GUARD_CYCLES + RST_CYCLES + 1 cycles. Implementation records the exact figure; the bench checks it.
- Glitches: a sel_id glitch shorter than STABLE_CYCLES causes no state change.
- Equal value: re-selecting the id already in target does nothing.

Decomposition:
- Shared package design_mux_pkg holds:
  - state enum (PARKED, DRAIN, RESET_HOLD, ACTIVE);
  - ID_NONE constant (all-ones);
  - the per-design bus slice helper function.
- One sub-module, sel_stable_filter: a parametrised candidate/count filter producing accepted and an accept pulse.

Test Plan:
- Reset, sel_id=1, defaults: io_oeb all 1 and des_rst=4'b1111 until cycle 29 (4+8+16+1). Then des_rst=4'b1101, active_id=1, and pads follow design 1 one cycle later. Pads 0..7 stay oeb=1.
- ACTIVE on id 1, sel_id pulses to 2 for 3 cycles then back to 1: no state change, busy stays 0, pads uninterrupted.
- Switch 1->3 during RESET_HOLD of a 0->1 switch: DRAIN restarts; design 1 never leaves reset; design 3 active after 29 cycles.
- sel_id=7 (invalid) while ACTIVE on 0: DRAIN for 8 cycles, then PARKED. des_rst=4'b1111, active_id=4'hF, io_oeb all 1.
- debug[0]=1 while ACTIVE: io_oeb=all 1 next cycle while des_rst and active_id unchanged. Clearing it restores the design-driven pads next cycle.
- Assert wb_rst_i asynchronously mid-ACTIVE, between clock edges: outputs reach reset values without a clock edge. After release, the block re-sequences to sel_id.
